// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered scanning decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational index to one-hot conversion; registered by the parent.
module decoder_onehot #(
    parameter int SEL_W = 5
) (
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   onehot
);

    // Exactly one bit set for every select code.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with direct hold and auto-scan modes.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter  int SEL_W = 5,
    parameter  int DWELL = 4,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [SEL_W-1:0] A,
    output logic [OUT_W-1:0] Y,
    output logic [SEL_W-1:0] idx,
    output logic             busy,
    output logic             wrap
);

    localparam int               DW         = cnt_width(DWELL);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = '1;

    if (SEL_W < 1 || SEL_W > 8) begin : g_bad_sel_w
        $error("decoder_scan_n: SEL_W must be in 1..8");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("decoder_scan_n: DWELL must be >= 1");
    end

    state_t           state, state_nx;
    logic [SEL_W-1:0] idx_nx;
    logic [DW-1:0]    dwell, dwell_nx;
    logic             wrap_nx;
    logic [OUT_W-1:0] y_dec;

    // Decode the next index so Y lands in the same edge as idx.
    decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
        .sel    (idx_nx),
        .onehot (y_dec)
    );

    // Next-state, index, dwell and wrap; priority en > load > mode > dwell step.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        dwell_nx = dwell;
        wrap_nx  = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else if (load) begin
            idx_nx   = A;
            dwell_nx = '0;
            state_nx = (mode == MODE_SCAN) ? SCAN : HOLD;
        end else if (state == SCAN) begin
            if (mode == MODE_DIRECT) begin
                state_nx = HOLD;
                dwell_nx = '0;
            end else if (dwell == DWELL_LAST) begin
                dwell_nx = '0;
                idx_nx   = idx + 1'b1;
                wrap_nx  = (idx == IDX_LAST);
            end else begin
                dwell_nx = dwell + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Registered outputs and dwell counter; Y is gated to zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            dwell <= '0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
            Y     <= '0;
        end else begin
            idx   <= idx_nx;
            dwell <= dwell_nx;
            wrap  <= wrap_nx;
            busy  <= (state_nx != IDLE);
            Y     <= (state_nx != IDLE) ? y_dec : '0;
        end
    end

endmodule
